// File: rtl/fll_cfg_arbiter.sv
// fll_cfg_arbiter
// Shares one FLL/PLL configuration port (req/ack, 2-bit address, 32-bit data,
// write-not-read) among NUM_REQ requesters. One transaction is in flight at a
// time and requesters are granted in round-robin order. The winner's command is
// latched at grant time, driven downstream until cfg_ack_i, and the read data
// plus a one-cycle acknowledge are returned to the winner.
//
// Optional feature: define FLL_CFG_TIMEOUT_EN to abort a transaction that sees
// no cfg_ack_i within TIMEOUT_CYCLES cycles. The aborted transaction gets
// req_err_o = 1 and read data 0. Without the macro, ISSUE waits indefinitely
// and req_err_o stays 0.
module fll_cfg_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*2-1:0]  req_add_i,
  input  logic [NUM_REQ*32-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]    req_wrn_i,
  output logic [NUM_REQ-1:0]    req_ack_o,
  output logic [31:0]           req_r_data_o,
  output logic                  req_err_o,
  output logic                  cfg_req_o,
  output logic [1:0]            cfg_add_o,
  output logic [31:0]           cfg_data_o,
  output logic                  cfg_wrn_o,
  input  logic                  cfg_ack_i,
  input  logic [31:0]           cfg_r_data_i,
  output logic                  busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Reject parameter values the arbiter is not built for.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("fll_cfg_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_last;
  logic [NUM_REQ-1:0] r_gnt_oh;
  logic [NUM_REQ-1:0] r_req_ack;
  logic [31:0]        r_r_data;
  logic               r_err;
  logic               r_cfg_req;
  logic [1:0]         r_cfg_add;
  logic [31:0]        r_cfg_data;
  logic               r_cfg_wrn;
  logic               r_busy;

  logic               w_gnt_valid;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic [1:0]         w_sel_add;
  logic [31:0]        w_sel_data;
  logic               w_sel_wrn;

`ifdef FLL_CFG_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_timeout;

  // The counter counts ISSUE cycles without ack; the abort happens on the edge
  // where it reaches TIMEOUT_CYCLES, so cfg_req_o is high exactly that many cycles.
  assign w_timeout = (r_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES);
`endif

  // Round-robin pick plus command mux: lowest requester above r_last wins,
  // otherwise the lowest requester at or below r_last (wrap-around).
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave a value held and infer a latch.
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    w_gnt_oh    = '0;
    w_sel_add   = '0;
    w_sel_data  = '0;
    w_sel_wrn   = 1'b0;
    // Later writes override earlier ones: the wrap-around pass goes first so
    // the pass above r_last has the final say, and each pass runs high-to-low
    // so the lowest index of a pass wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i] && (IDX_W'(i) <= r_last)) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = IDX_W'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i] && (IDX_W'(i) > r_last)) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_idx == IDX_W'(i)) begin
        w_gnt_oh[i] = 1'b1;
        w_sel_add   = req_add_i[i*2 +: 2];
        w_sel_data  = req_data_i[i*32 +: 32];
        w_sel_wrn   = req_wrn_i[i];
      end
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    if (rst_i) begin
      r_state    <= IDLE;
      r_last     <= IDX_W'(NUM_REQ - 1);
      r_gnt_oh   <= '0;
      r_req_ack  <= '0;
      r_r_data   <= '0;
      r_err      <= 1'b0;
      r_cfg_req  <= 1'b0;
      r_cfg_add  <= '0;
      r_cfg_data <= '0;
      r_cfg_wrn  <= 1'b0;
      r_busy     <= 1'b0;
`ifdef FLL_CFG_TIMEOUT_EN
      r_cnt      <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_state    <= ISSUE;
            r_busy     <= 1'b1;
            r_cfg_req  <= 1'b1;
            r_cfg_add  <= w_sel_add;
            r_cfg_data <= w_sel_data;
            r_cfg_wrn  <= w_sel_wrn;
            r_last     <= w_gnt_idx;
            r_gnt_oh   <= w_gnt_oh;
`ifdef FLL_CFG_TIMEOUT_EN
            r_cnt      <= '0;
`endif
          end
        end
        ISSUE: begin
          // An ack takes priority over a timeout reached in the same cycle.
          if (cfg_ack_i) begin
            r_state   <= RESP;
            r_cfg_req <= 1'b0;
            r_r_data  <= cfg_r_data_i;
            r_err     <= 1'b0;
            r_req_ack <= r_gnt_oh;
          end
`ifdef FLL_CFG_TIMEOUT_EN
          else if (w_timeout) begin
            r_state   <= RESP;
            r_cfg_req <= 1'b0;
            r_r_data  <= '0;
            r_err     <= 1'b1;
            r_req_ack <= r_gnt_oh;
            r_cnt     <= r_cnt + CNT_W'(1);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_req_ack <= '0;
          r_err     <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ack_o    = r_req_ack;
  assign req_r_data_o = r_r_data;
  assign req_err_o    = r_err;
  assign cfg_req_o    = r_cfg_req;
  assign cfg_add_o    = r_cfg_add;
  assign cfg_data_o   = r_cfg_data;
  assign cfg_wrn_o    = r_cfg_wrn;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_fll_cfg_arbiter.sv
// tb_fll_cfg_arbiter
// Self-checking bench for fll_cfg_arbiter with three requesters: a table of
// single transactions, hand-written multi-cycle sequences (contention, reset
// during ISSUE, stray acks, timeout when FLL_CFG_TIMEOUT_EN is defined) and a
// randomized run checked against a timeline/scoreboard model of the arbiter.
module tb_fll_cfg_arbiter;

  localparam int N   = 3;
  localparam int TMO = 8;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_i;
  logic [N*2-1:0]  req_add_i;
  logic [N*32-1:0] req_data_i;
  logic [N-1:0]    req_wrn_i;
  logic [N-1:0]    req_ack_o;
  logic [31:0]     req_r_data_o;
  logic            req_err_o;
  logic            cfg_req_o;
  logic [1:0]      cfg_add_o;
  logic [31:0]     cfg_data_o;
  logic            cfg_wrn_o;
  logic            cfg_ack_i;
  logic [31:0]     cfg_r_data_i;
  logic            busy_o;

  fll_cfg_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .req_add_i    (req_add_i),
    .req_data_i   (req_data_i),
    .req_wrn_i    (req_wrn_i),
    .req_ack_o    (req_ack_o),
    .req_r_data_o (req_r_data_o),
    .req_err_o    (req_err_o),
    .cfg_req_o    (cfg_req_o),
    .cfg_add_o    (cfg_add_o),
    .cfg_data_o   (cfg_data_o),
    .cfg_wrn_o    (cfg_wrn_o),
    .cfg_ack_i    (cfg_ack_i),
    .cfg_r_data_i (cfg_r_data_i),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          id;
    logic [1:0]  add;
    logic [31:0] data;
    logic        wrn;
    int          lat;
    logic [31:0] rd;
    logic [N-1:0] exp_ack;
    logic [1:0]  exp_add;
    logic [31:0] exp_data;
    logic        exp_wrn;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [5];

  // Random-phase model state: transaction timeline and round-robin pointer.
  int           t_grant;
  int           t_ack;
  int           m_win;
  int           m_last;
  logic [N-1:0] m_oh;
  logic [1:0]   m_add;
  logic [31:0]  m_data;
  logic         m_wrn;
  logic [31:0]  m_rd;
  int           waits [N];
  bit           in_txn;
  bit           e_req;
  logic [N-1:0] e_ack;
  bit           found;
  int           waited;
  int           hi_cycles;
  logic [31:0]  last_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_cmd(input int id, input logic [1:0] add, input logic [31:0] data,
                         input logic wrn);
    req_add_i[id*2 +: 2]   = add;
    req_data_i[id*32 +: 32] = data;
    req_wrn_i[id]          = wrn;
  endtask

  task automatic check_all_zero(input string name);
    check({name, " req_ack"},  32'(req_ack_o), 0);
    check({name, " r_data"},   req_r_data_o,   0);
    check({name, " err"},      32'(req_err_o), 0);
    check({name, " cfg_req"},  32'(cfg_req_o), 0);
    check({name, " cfg_add"},  32'(cfg_add_o), 0);
    check({name, " cfg_data"}, cfg_data_o,     0);
    check({name, " cfg_wrn"},  32'(cfg_wrn_o), 0);
    check({name, " busy"},     32'(busy_o),    0);
  endtask

  task automatic do_reset();
    rst_i        = 1'b1;
    req_i        = '0;
    cfg_ack_i    = 1'b0;
    cfg_r_data_i = 32'h0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Bounded wait for cfg_req_o; waited = extra cycles beyond the next one.
  task automatic wait_cfg_req(input string name, output int w);
    w = 0;
    @(negedge clk_i);
    while (cfg_req_o !== 1'b1 && w < 20) begin
      @(negedge clk_i);
      w++;
    end
    check({name, " cfg_req rise"}, 32'(cfg_req_o), 1);
  endtask

  // Serve one transaction of requester id; the caller has already raised req_i[id].
  task automatic serve(input string name, input int id, input logic [1:0] add,
                       input logic [31:0] data, input logic wrn, input int lat,
                       input logic [31:0] rd, input logic [N-1:0] exp_ack,
                       input int exp_wait, input bit drop);
    int w;
    wait_cfg_req(name, w);
    check({name, " grant latency"}, w, exp_wait);
    check({name, " cfg_add"},  32'(cfg_add_o), 32'(add));
    check({name, " cfg_data"}, cfg_data_o,     data);
    check({name, " cfg_wrn"},  32'(cfg_wrn_o), 32'(wrn));
    check({name, " busy"},     32'(busy_o),    1);
    // The granted requester changes its command; the latched one must not move.
    set_cmd(id, ~add, ~data, ~wrn);
    for (int k = 0; k < lat; k++) begin
      @(negedge clk_i);
      check({name, " cfg_req held"}, 32'(cfg_req_o), 1);
      check({name, " cfg_add held"}, 32'(cfg_add_o), 32'(add));
      check({name, " cfg_data held"}, cfg_data_o,    data);
      check({name, " cfg_wrn held"}, 32'(cfg_wrn_o), 32'(wrn));
      check({name, " no early ack"}, 32'(req_ack_o), 0);
    end
    cfg_ack_i    = 1'b1;
    cfg_r_data_i = rd;
    @(negedge clk_i);
    cfg_ack_i    = 1'b0;
    cfg_r_data_i = $urandom;
    check({name, " req_ack"}, 32'(req_ack_o), 32'(exp_ack));
    check({name, " r_data"},  req_r_data_o,   rd);
    check({name, " err"},     32'(req_err_o), 0);
    check({name, " cfg_req drop"}, 32'(cfg_req_o), 0);
    check({name, " busy resp"}, 32'(busy_o), 1);
    if (drop) req_i[id] = 1'b0;
  endtask

  initial begin
    vecs[0] = '{id: 0, add: 2'd2, data: 32'h0000_0000, wrn: 1'b1, lat: 5, rd: 32'hA5A5_0001,
                exp_ack: 3'b001, exp_add: 2'd2, exp_data: 32'h0000_0000, exp_wrn: 1'b1,
                exp_rdata: 32'hA5A5_0001};
    vecs[1] = '{id: 1, add: 2'd1, data: 32'h1234_5678, wrn: 1'b0, lat: 3, rd: 32'hDEAD_BEEF,
                exp_ack: 3'b010, exp_add: 2'd1, exp_data: 32'h1234_5678, exp_wrn: 1'b0,
                exp_rdata: 32'hDEAD_BEEF};
    vecs[2] = '{id: 2, add: 2'd0, data: 32'h0F0F_0F0F, wrn: 1'b1, lat: 0, rd: 32'h0000_FFFF,
                exp_ack: 3'b100, exp_add: 2'd0, exp_data: 32'h0F0F_0F0F, exp_wrn: 1'b1,
                exp_rdata: 32'h0000_FFFF};
    vecs[3] = '{id: 0, add: 2'd3, data: 32'hFFFF_FFFF, wrn: 1'b0, lat: 1, rd: 32'h1111_2222,
                exp_ack: 3'b001, exp_add: 2'd3, exp_data: 32'hFFFF_FFFF, exp_wrn: 1'b0,
                exp_rdata: 32'h1111_2222};
    vecs[4] = '{id: 2, add: 2'd3, data: 32'h8000_0001, wrn: 1'b1, lat: 2, rd: 32'h8000_0001,
                exp_ack: 3'b100, exp_add: 2'd3, exp_data: 32'h8000_0001, exp_wrn: 1'b1,
                exp_rdata: 32'h8000_0001};

    req_add_i  = '0;
    req_data_i = '0;
    req_wrn_i  = '0;
    do_reset();
    check_all_zero("reset");

    // Table: isolated transactions, each issued from IDLE.
    for (int v = 0; v < 5; v++) begin
      @(negedge clk_i);
      check($sformatf("vec%0d idle busy", v), 32'(busy_o), 0);
      set_cmd(vecs[v].id, vecs[v].add, vecs[v].data, vecs[v].wrn);
      req_i[vecs[v].id] = 1'b1;
      serve($sformatf("vec%0d", v), vecs[v].id, vecs[v].exp_add, vecs[v].exp_data,
            vecs[v].exp_wrn, vecs[v].lat, vecs[v].exp_rdata, vecs[v].exp_ack, 0, 1'b1);
    end

    // Contention after reset: 0 first, then 1, and a re-request of 0 waits for 1.
    do_reset();
    set_cmd(0, 2'd3, 32'h0000_0A0A, 1'b1);
    set_cmd(1, 2'd0, 32'h0000_0B0B, 1'b0);
    req_i[0] = 1'b1;
    req_i[1] = 1'b1;
    serve("cont r0", 0, 2'd3, 32'h0000_0A0A, 1'b1, 2, 32'hC0C0_0001, 3'b001, 0, 1'b0);
    set_cmd(0, 2'd2, 32'h0000_0C0C, 1'b0);
    serve("cont r1", 1, 2'd0, 32'h0000_0B0B, 1'b0, 1, 32'hC0C0_0002, 3'b010, 1, 1'b1);
    serve("cont r0 again", 0, 2'd2, 32'h0000_0C0C, 1'b0, 0, 32'hC0C0_0003, 3'b001, 1, 1'b1);

    // Reset pulse while requester 0 is in ISSUE: everything clears, pointer restarts.
    @(negedge clk_i);
    set_cmd(0, 2'd1, 32'h5555_AAAA, 1'b1);
    req_i[0] = 1'b1;
    wait_cfg_req("rst issue", waited);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i    = 1'b0;
    req_i[0] = 1'b0;
    check_all_zero("rst issue");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("rst no ack", 32'(req_ack_o), 0);
      check("rst no cfg_req", 32'(cfg_req_o), 0);
    end
    set_cmd(0, 2'd2, 32'h0000_00A0, 1'b1);
    set_cmd(1, 2'd3, 32'h0000_00B0, 1'b1);
    req_i[0] = 1'b1;
    req_i[1] = 1'b1;
    serve("post rst r0", 0, 2'd2, 32'h0000_00A0, 1'b1, 1, 32'h7777_0000, 3'b001, 0, 1'b1);
    serve("post rst r1", 1, 2'd3, 32'h0000_00B0, 1'b1, 1, 32'h7777_0001, 3'b010, 1, 1'b1);
    last_rd = 32'h7777_0001;

    // Stray ack while IDLE is ignored.
    @(negedge clk_i);
    cfg_ack_i    = 1'b1;
    cfg_r_data_i = 32'hBAD0_BAD0;
    @(negedge clk_i);
    cfg_ack_i = 1'b0;
    check("idle ack busy", 32'(busy_o), 0);
    check("idle ack req_ack", 32'(req_ack_o), 0);
    check("idle ack cfg_req", 32'(cfg_req_o), 0);
    check("idle ack r_data", req_r_data_o, last_rd);

`ifdef FLL_CFG_TIMEOUT_EN
    // No ack: cfg_req_o stays high exactly TMO cycles, then an error ack with data 0.
    set_cmd(1, 2'd2, 32'h0000_0000, 1'b1);
    req_i[1] = 1'b1;
    wait_cfg_req("tmo", waited);
    check("tmo grant latency", waited, 0);
    hi_cycles = 1;
    while (cfg_req_o === 1'b1 && hi_cycles < 40) begin
      @(negedge clk_i);
      if (cfg_req_o === 1'b1) hi_cycles++;
    end
    check("tmo cfg_req cycles", hi_cycles, TMO);
    check("tmo req_ack", 32'(req_ack_o), 32'b010);
    check("tmo err", 32'(req_err_o), 1);
    check("tmo r_data", req_r_data_o, 0);
    req_i[1] = 1'b0;
    @(negedge clk_i);
    cfg_ack_i    = 1'b1;
    cfg_r_data_i = 32'hFEED_FACE;
    @(negedge clk_i);
    cfg_ack_i = 1'b0;
    check("tmo late ack busy", 32'(busy_o), 0);
    check("tmo late ack req_ack", 32'(req_ack_o), 0);
    check("tmo late ack err", 32'(req_err_o), 0);
    check("tmo late ack cfg_req", 32'(cfg_req_o), 0);
    // Ack on the very cycle the timeout would fire: the ack wins.
    set_cmd(0, 2'd1, 32'h0000_0001, 1'b1);
    req_i[0] = 1'b1;
    serve("ack at tmo", 0, 2'd1, 32'h0000_0001, 1'b1, TMO - 1, 32'h3C3C_5A5A, 3'b001, 0, 1'b1);
`endif

    // Randomized run against the timeline/scoreboard model.
    do_reset();
    m_last  = N - 1;
    t_grant = -1;
    t_ack   = -1;
    m_win   = 0;
    m_oh    = '0;
    for (int i = 0; i < N; i++) waits[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      in_txn = (t_grant >= 0);
      e_req  = in_txn && (t_ack < 0);
      e_ack  = (in_txn && t_ack >= 0 && c == t_ack + 1) ? m_oh : '0;
      check("rnd cfg_req", 32'(cfg_req_o), 32'(e_req));
      check("rnd busy", 32'(busy_o), 32'(in_txn));
      check("rnd req_ack", 32'(req_ack_o), 32'(e_ack));
      check("rnd err", 32'(req_err_o), 0);
      if (e_req) begin
        check("rnd cfg_add", 32'(cfg_add_o), 32'(m_add));
        check("rnd cfg_data", cfg_data_o, m_data);
        check("rnd cfg_wrn", 32'(cfg_wrn_o), 32'(m_wrn));
      end
      if (e_ack != '0) begin
        check("rnd r_data", req_r_data_o, m_rd);
        req_i[m_win] = 1'b0;
        t_grant = -1;
        t_ack   = -1;
      end
      // Requesters: raise new requests, and waiting/granted ones may scribble.
      for (int i = 0; i < N; i++) begin
        if (!req_i[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_i[i] = 1'b1;
            waits[i] = 0;
            set_cmd(i, 2'($urandom), $urandom, 1'($urandom));
          end
        end else if ($urandom_range(0, 3) == 0) begin
          set_cmd(i, 2'($urandom), $urandom, 1'($urandom));
        end
      end
      // Grant decision in a free cycle, rotating priority from the last winner.
      if (!in_txn && req_i != '0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          if (!found && req_i[(m_last + k) % N]) begin
            found = 1'b1;
            m_win = (m_last + k) % N;
          end
        end
        check("rnd fairness", 32'(waits[m_win] <= N - 1), 1);
        for (int i = 0; i < N; i++) begin
          if (i != m_win && req_i[i]) waits[i]++;
        end
        waits[m_win] = 0;
        m_last  = m_win;
        m_oh    = '0;
        m_oh[m_win] = 1'b1;
        m_add   = req_add_i[m_win*2 +: 2];
        m_data  = req_data_i[m_win*32 +: 32];
        m_wrn   = req_wrn_i[m_win];
        t_grant = c;
      end
      // Downstream responder: random latency capped well under the timeout,
      // plus stray acks when no request is outstanding.
      if (e_req) begin
        if ($urandom_range(0, 2) == 0 || (c - t_grant) >= 6) begin
          m_rd         = $urandom;
          cfg_ack_i    = 1'b1;
          cfg_r_data_i = m_rd;
          t_ack        = c;
        end else begin
          cfg_ack_i    = 1'b0;
          cfg_r_data_i = $urandom;
        end
      end else begin
        cfg_ack_i    = ($urandom_range(0, 3) == 0);
        cfg_r_data_i = $urandom;
      end
    end
    cfg_ack_i = 1'b0;
    req_i     = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
